// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: time-slices NDIGITS digits onto shared cathodes,
// with a frame-synchronous shadow copy of the display value, PWM dimming and guard blanking.
module sevenseg_scan_ctrl #(
    parameter int NDIGITS    = 8,
    parameter int CLK_DIV    = 1000,
    parameter int GUARD      = 2,
    parameter int PWM_BITS   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   hold,
    input  logic [NDIGITS-1:0]     digit_en,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   lz_suppress,
    input  logic [PWM_BITS-1:0]    brightness,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             seg,
    output logic                   seg_dp,
    output logic                   frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [NDIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]         SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic               DP_OFF  = (ACTIVE_LOW != 0);

    logic [PW-1:0]        p;
    logic [IW-1:0]        idx;
    logic [4*NDIGITS-1:0] shadow;
    logic                 first_cycle;

    logic                 slot_end;
    logic                 last_digit;
    logic                 boundary;
    logic [3:0]           nibble;
    logic                 en_bit;
    logic                 dp_bit;
    logic                 lz_bit;
    logic                 zero_run;
    logic                 lit;
    logic [NDIGITS-1:0]   an_next;
    logic [6:0]           seg_next;
    logic                 seg_dp_next;

    // Segment patterns are stored in active-low form; polarity is applied at the output.
    function automatic logic [6:0] decode7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign slot_end   = (p == PW'(CLK_DIV - 1));
    assign last_digit = (idx == IW'(NDIGITS - 1));
    assign boundary   = first_cycle || (slot_end && last_digit);

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        nibble   = 4'h0;
        en_bit   = 1'b0;
        dp_bit   = 1'b0;
        lz_bit   = 1'b0;
        zero_run = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nibble = shadow[4*i +: 4];
                en_bit = digit_en[i];
                dp_bit = dp[i];
                lz_bit = lz_suppress && (i != 0) && zero_run;
            end
        end
    end

    always_comb begin
        lit = en_bit && !lz_bit && (int'(p) >= GUARD) && (p[PWM_BITS-1:0] <= brightness);
        an_next     = (lit ? (NDIGITS'(1) << idx) : '0) ^ AN_OFF;
        seg_next    = lit ? (decode7(nibble) ^ ~SEG_OFF) : SEG_OFF;
        seg_dp_next = (lit && dp_bit) ^ DP_OFF;
    end

    // Scan position and shadow register; the shadow only changes at frame boundaries.
    always_ff @(posedge clk) begin
        if (Rst) begin
            p           <= '0;
            idx         <= '0;
            shadow      <= '0;
            first_cycle <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            p           <= slot_end ? '0 : p + 1'b1;
            first_cycle <= 1'b0;
            frame_done  <= boundary;
            if (slot_end) begin
                idx <= last_digit ? '0 : idx + 1'b1;
            end
            if (boundary && !hold) begin
                shadow <= value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            seg_dp <= DP_OFF;
        end else begin
            an     <= an_next;
            seg    <= seg_next;
            seg_dp <= seg_dp_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: an arithmetic scan model checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_sevenseg_scan_ctrl;

    localparam int NDIGITS    = 8;
    localparam int CLK_DIV    = 16;
    localparam int GUARD      = 2;
    localparam int PWM_BITS   = 4;
    localparam int ACTIVE_LOW = 1;
    localparam int FRAME      = NDIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] value;
    logic        hold;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic        lz_suppress;
    logic [3:0]  brightness;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame_done;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(
        .NDIGITS(NDIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD),
        .PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .Rst(Rst), .value(value), .hold(hold), .digit_en(digit_en),
        .dp(dp), .lz_suppress(lz_suppress), .brightness(brightness),
        .an(an), .seg(seg), .seg_dp(seg_dp), .frame_done(frame_done)
    );

    int checks = 0;
    int passed = 0;

    int          k;
    int          slot;
    int          pp;
    int          out_slot = -1;
    int          out_p = -1;
    bit          model_ready = 0;
    bit          lit;
    bit          zero_run;
    bit          lzb;
    logic [3:0]  nib;
    logic [31:0] m_shadow;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;
    logic [6:0]  seg_tab [16];

    logic [7:0]  lit_mask;
    logic [7:0]  dp_mask;
    int          lit_cycles [8];
    int          total_lit;
    int          dp_cycles;
    int          stray_dp;
    logic [6:0]  last_seg [8];

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
    end

    // The model works from elapsed cycles since reset: slot and phase are plain division.
    always @(posedge clk) begin
        if (Rst) begin
            k        = 0;
            m_shadow = '0;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_fd   = 1'b0;
            out_slot = -1;
            out_p    = -1;
        end else begin
            slot = (k / CLK_DIV) % NDIGITS;
            pp   = k % CLK_DIV;
            nib  = m_shadow[4*slot +: 4];
            zero_run = 1;
            for (int i = slot; i < NDIGITS; i++)
                if (m_shadow[4*i +: 4] != 4'h0) zero_run = 0;
            lzb = lz_suppress && (slot != 0) && zero_run;
            lit = digit_en[slot] && !lzb && (pp >= GUARD) && ((pp % 16) <= int'(brightness));
            exp_an  = lit ? ~(8'b1 << slot) : 8'hFF;
            exp_seg = lit ? seg_tab[nib] : 7'h7F;
            exp_dp  = !(lit && dp[slot]);
            exp_fd  = (k == 0) || (k % FRAME == FRAME - 1);
            if (exp_fd && !hold) m_shadow = value;
            out_slot = slot;
            out_p    = pp;
            k++;
        end
        model_ready = 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("model_an", 32'(an), 32'(exp_an));
            checkOutput("model_seg", 32'(seg), 32'(exp_seg));
            checkOutput("model_seg_dp", 32'(seg_dp), 32'(exp_dp));
            checkOutput("model_frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] v, input logic h, input logic [7:0] en,
                                 input logic [7:0] d, input logic lz, input logic [3:0] br);
        value       = v;
        hold        = h;
        digit_en    = en;
        dp          = d;
        lz_suppress = lz;
        brightness  = br;
    endtask

    task automatic waitOut(input int s, input int p);
        bit found = 0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            tick();
            if (out_slot == s && out_p == p) found = 1;
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL wait_slot: slot %0d p %0d reached 0, required 1", s, p);
        end
    endtask

    task automatic waitFd();
        bit found = 0;
        for (int n = 0; n < FRAME + 8 && !found; n++) begin
            tick();
            if (frame_done === 1'b1) found = 1;
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL wait_frame_done: pulse seen 0, required 1");
        end
    endtask

    // Collects what the display shows across one whole frame, starting at a boundary.
    task automatic scanFrame();
        lit_mask  = '0;
        dp_mask   = '0;
        total_lit = 0;
        dp_cycles = 0;
        stray_dp  = 0;
        for (int d = 0; d < 8; d++) begin
            lit_cycles[d] = 0;
            last_seg[d]   = 7'h7F;
        end
        waitFd();
        for (int n = 0; n < FRAME; n++) begin
            tick();
            if (an == 8'hFF && seg_dp == 1'b0) stray_dp++;
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'b1 << d)) begin
                    lit_mask[d] = 1'b1;
                    lit_cycles[d]++;
                    total_lit++;
                    last_seg[d] = seg;
                    if (seg_dp == 1'b0) begin
                        dp_mask[d] = 1'b1;
                        dp_cycles++;
                    end
                end
            end
        end
    endtask

    int period;

    initial begin
        Rst = 1'b1;
        applyStimulus(32'hDEADBEEF, 1'b0, 8'hFF, 8'hFF, 1'b1, 4'hF);
        repeat (3) tick();
        checkOutput("reset_an", 32'(an), 32'h0000_00FF);
        checkOutput("reset_seg", 32'(seg), 32'h0000_007F);
        checkOutput("reset_seg_dp", 32'(seg_dp), 32'h1);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);

        applyStimulus(32'h89ABCDEF, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        Rst = 1'b0;
        tick();
        checkOutput("first_frame_done", 32'(frame_done), 32'h1);

        waitOut(0, 5);
        checkOutput("slot0_an", 32'(an), 32'h0000_00FE);
        checkOutput("slot0_seg", 32'(seg), 32'(7'b0111000));
        waitOut(7, 9);
        checkOutput("slot7_an", 32'(an), 32'h0000_007F);
        checkOutput("slot7_seg", 32'(seg), 32'(7'b0000000));
        waitOut(3, 1);
        checkOutput("guard_an", 32'(an), 32'h0000_00FF);
        waitFd();
        period = 0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            tick();
            period++;
            if (frame_done === 1'b1) break;
        end
        checkOutput("frame_period", 32'(period), 32'd128);

        applyStimulus(32'h00000340, 1'b0, 8'hFF, 8'h00, 1'b1, 4'hF);
        scanFrame();
        checkOutput("lz_mask", 32'(lit_mask), 32'h07);
        checkOutput("lz_digit2_seg", 32'(last_seg[2]), 32'(7'b0000110));
        checkOutput("lz_digit1_seg", 32'(last_seg[1]), 32'(7'b1001100));
        checkOutput("lz_digit0_seg", 32'(last_seg[0]), 32'(7'b0000001));
        applyStimulus(32'h00000000, 1'b0, 8'hFF, 8'h00, 1'b1, 4'hF);
        scanFrame();
        checkOutput("lz_zero_mask", 32'(lit_mask), 32'h01);
        applyStimulus(32'h00000000, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        scanFrame();
        checkOutput("nolz_mask", 32'(lit_mask), 32'hFF);
        checkOutput("full_lit_cycles", 32'(lit_cycles[4]), 32'd14);

        applyStimulus(32'h89ABCDEF, 1'b0, 8'hFF, 8'h04, 1'b0, 4'h3);
        scanFrame();
        checkOutput("dim_slot0_cycles", 32'(lit_cycles[0]), 32'd2);
        checkOutput("dim_slot5_cycles", 32'(lit_cycles[5]), 32'd2);
        checkOutput("dim_total", 32'(total_lit), 32'd16);
        checkOutput("dp_mask", 32'(dp_mask), 32'h04);
        checkOutput("dp_cycles", 32'(dp_cycles), 32'd2);
        checkOutput("dp_stray", 32'(stray_dp), 32'd0);
        applyStimulus(32'h89ABCDEF, 1'b0, 8'hFF, 8'h04, 1'b0, 4'h0);
        scanFrame();
        checkOutput("dark_total", 32'(total_lit), 32'd0);

        applyStimulus(32'h12345678, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        waitFd();
        waitOut(4, 0);
        applyStimulus(32'h87654321, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        waitOut(6, 8);
        checkOutput("tearfree_old", 32'(seg), 32'(7'b0010010));
        waitFd();
        waitOut(6, 8);
        checkOutput("tearfree_new", 32'(seg), 32'(7'b0001111));
        applyStimulus(32'h00000000, 1'b1, 8'hFF, 8'h00, 1'b0, 4'hF);
        repeat (3) waitFd();
        waitOut(6, 8);
        checkOutput("hold_retained", 32'(seg), 32'(7'b0001111));
        applyStimulus(32'h00000000, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        waitOut(6, 9);
        checkOutput("hold_release_same_frame", 32'(seg), 32'(7'b0001111));
        waitFd();
        waitOut(6, 8);
        checkOutput("hold_released", 32'(seg), 32'(7'b0000001));

        waitOut(5, 6);
        applyStimulus(32'h11111111, 1'b0, 8'hFF, 8'h00, 1'b0, 4'hF);
        Rst = 1'b1;
        tick();
        checkOutput("midreset_an", 32'(an), 32'h0000_00FF);
        checkOutput("midreset_seg", 32'(seg), 32'h0000_007F);
        checkOutput("midreset_frame_done", 32'(frame_done), 32'h0);
        Rst = 1'b0;
        tick();
        checkOutput("midreset_reload_fd", 32'(frame_done), 32'h1);
        waitOut(0, 4);
        checkOutput("restart_an", 32'(an), 32'h0000_00FE);
        checkOutput("restart_seg", 32'(seg), 32'(7'b1001111));

        tick();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display scanner. It is the generalised replacement for the fixed 8-digit anode/segment scan logic in the SoC top level. It adds:
- configurable digit count and active polarity
- a tear-free frame-synchronous shadow register
- per-digit enable and decimal point
- leading-zero suppression
- PWM brightness control
- anti-ghosting guard cycles

It sits between the debug/display data source and the board anode/cathode pins.

Parameters:
NDIGITS, 8, number of digits scanned (1..16)
CLK_DIV, 1000, clk cycles per digit slot; must be > GUARD and >= 2**PWM_BITS
GUARD, 2, blanking cycles at the start of each slot (anodes off)
PWM_BITS, 4, width of brightness control
ACTIVE_LOW, 1, 1: an/seg/seg_dp active-low; 0: active-high

Ports:
clk  input  1  system clock, single clock domain
Rst  input  1  synchronous reset, active-high
value  input  4*NDIGITS  hex nibbles; digit i = value[4i+3:4i]
hold  input  1  1 = freeze shadow register at frame boundaries
digit_en  input  NDIGITS  per-digit enable; 0 = digit dark
dp  input  NDIGITS  per-digit decimal point request
lz_suppress  input  1  1 = blank leading zero digits
brightness  input  PWM_BITS  duty control
an  output  NDIGITS  anode drives
seg  output  7  segments {a,b,c,d,e,f,g}
seg_dp  output  1  decimal point segment
frame_done  output  1  one-cycle pulse at frame wrap

Behaviour:
- Single clock clk. All state is updated on posedge clk. Rst is synchronous and active-high and overrides everything.

Reset:
- p=0, idx=0, shadow=0.
- an = all inactive (all 1s if ACTIVE_LOW).
- seg = blank (7'b1111111 if ACTIVE_LOW, else 0).
- seg_dp inactive; frame_done=0.
- Rst asserted mid-frame: the next cycle has idx=0, p=0 and outputs blank. Scanning restarts at digit 0 when Rst deasserts.

Prescaler:
- p counts 0..CLK_DIV-1 and wraps.
- On p==CLK_DIV-1: idx advances, wrapping NDIGITS-1 -> 0. p returns to 0.

Frame boundary (idx wraps NDIGITS-1 -> 0, and first cycle after reset deassert):
- If hold=0, shadow <= value.
- frame_done pulses for one cycle in the same cycle that idx becomes 0.
- If hold=1, shadow is retained. frame_done still pulses.
- value changes mid-frame are never visible until the next boundary.

Digit visibility for slot idx:
- lit = digit_en[idx] && !lz_blank[idx] && (p >= GUARD) && pwm_on.
- pwm_on = (p[PWM_BITS-1:0] <= brightness). brightness all-ones gives full on outside guard.
- lz_blank[i] = lz_suppress && (i != 0) && all shadow nibbles i..NDIGITS-1 are zero. Digit 0 is never suppressed.

Segment decode (logical, active-low form, {a..g}):
- 0:0000001, 1:1001111, 2:0010010, 3:0000110
- 4:1001100, 5:0100100, 6:0100000, 7:0001111
- 8:0000000, 9:0000100, A:0001000, b:1100000
- C:0110001, d:1000010, E:0110000, F:0111000
- ACTIVE_LOW=0 inverts all outputs.

Outputs (all registered, 1-cycle latency from (idx,p)):
- an: only bit idx active when lit; all inactive otherwise.
- seg: decode(shadow nibble idx) when lit, else blank.
- seg_dp: active when lit && dp[idx].

Other rules:
- digit_en, dp, lz_suppress and brightness are sampled live; they take effect with 1-cycle latency and have no frame sync.
- No two anodes are ever simultaneously active. There are at least GUARD blank cycles between consecutive digits.
- NDIGITS=1: every slot boundary is a frame boundary, so frame_done pulses once per CLK_DIV cycles.

Test Plan:
Unless stated, benches use NDIGITS=8, CLK_DIV=16, GUARD=2, PWM_BITS=4, ACTIVE_LOW=1.

1. Reset: hold Rst 3 cycles with any inputs -> an=8'hFF, seg=7'h7F, seg_dp=1, frame_done=0. First frame_done occurs 1 cycle after deassert.
2. Full scan: value=32'h89ABCDEF, digit_en=8'hFF, brightness=15 ->
   - slot 0: an=8'hFE for cycles p=2..15 (+1 latency), seg=7'b0111000.
   - slot 7: an=8'h7F, seg=7'b0000000.
   - an=8'hFF during guard cycles.
   - frame_done period = 128 cycles.
3. Leading zeros: value=32'h00000340, lz_suppress=1 -> digits 7..3 never lit; digit 2 seg=7'b0000110; digit 0 seg=7'b0000001. value=0 -> only digit 0 lit. lz_suppress=0 -> all 8 lit.
4. Brightness/dp: brightness=3, dp=8'h04 -> each slot lit only at p=2,3 (2 cycles); seg_dp=0 only during digit 2 lit cycles. brightness=0 -> 0 lit cycles (p=0 falls in guard).
5. Tear-free/hold: change value at mid-frame (idx=4) -> displayed nibbles unchanged until after the next frame_done. With hold=1 across 3 frames -> old value persists. Deassert hold -> new value at the next boundary.
6. Mid-frame reset: assert Rst 1 cycle at idx=5, p=7 -> next cycle all outputs blank. After deassert, digit 0 is scanned first and shadow is reloaded.
